mem_bus_adapter: RTL and testbench
==================================

Name: mem_bus_adapter

Overview:
Sits directly downstream of the multi-cycle CPU's memory port (address mux output, B-register write data, mem write enable). It converts the CPU's single-cycle memory access into a req/ack handshake toward a slower external memory. It returns read data plus a stall signal that freezes the CPU control FSM until the access completes. It also flags misaligned and timed-out accesses.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles ext_req is held without ext_ack before abort (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on error

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_addr  input  AW  byte address from CPU memory-address mux
cpu_wdata  input  DW  store data (B register)
cpu_we  input  1  store request
cpu_re  input  1  load/fetch request
cpu_rdata  output  DW  registered read data to MDR/IR
stall  output  1  CPU must hold state and control signals while high
err  output  1  one-cycle pulse: misaligned or timeout
ext_req  output  1  external request, registered
ext_we  output  1  external write qualifier
ext_addr  output  AW  external address, word aligned
ext_wdata  output  DW  external write data
ext_ack  input  1  external completion, single-cycle pulse
ext_rdata  input  DW  external read data, valid with ext_ack

Behaviour:
- Reset (reset low, async): state IDLE; ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, cpu_rdata=0, err=0, counter=0. Reset mid-access drops ext_req immediately. Any later ext_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE, no cpu_re/cpu_we: stall=0, hold.
- IDLE, request seen (cpu_re|cpu_we):
  - stall=1 combinationally, same cycle.
  - If both are high, write wins.
  - If cpu_addr[1:0]!=0 (misaligned): no external access. Next cycle goes to DONE with err=1; on a read, cpu_rdata=ERR_DATA.
  - Otherwise: on the clock edge, latch addr/wdata/we into the ext_* registers, set ext_req=1, clear counter, go to REQ.
- REQ:
  - stall=1; ext_* are held stable; counter increments each cycle.
  - ext_ack=1: ext_req=0 on the next edge.
    - Read: cpu_rdata<=ext_rdata.
    - Write: cpu_rdata unchanged.
    - Go to DONE.
  - counter==TIMEOUT-1 with no ack: ext_req=0, err=1 (registered, visible in DONE). Read: cpu_rdata<=ERR_DATA. Go to DONE.
  - Ack on the same cycle as the timeout boundary: ack wins, no err.
- DONE:
  - Exactly one cycle; stall=0, so the CPU FSM advances on this edge.
  - cpu_re/cpu_we are ignored this cycle, so a held request is not reissued. Return to IDLE.
  - err is high only in DONE.
- Latency: request seen in cycle 0, ext_req high from cycle 1. Ack in cycle k≥1 gives DONE in cycle k+1. Minimum is 3 cycles total, with stall high in cycles 0..k.
- ext_ack in IDLE or DONE is ignored; a late ack after timeout is ignored.
- cpu_rdata holds its last value between accesses.
- Counter width is clog2(TIMEOUT+1); it never wraps because it is cleared on entry to REQ.

Decomposition:
- Shared include mcpu_mem_defs.v:
  - state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_DONE=2'd2 (2'd3 illegal, recovers to IDLE)
  - ERR_DATA default
  - alignment mask constant
- One sub-module, mem_timeout_ctr: clear, enable, and terminal-count output, parameterised by TIMEOUT, async active-low reset.
- Handshake FSM and data registers stay in mem_bus_adapter.

Test Plan:
- Aligned read, ack in first REQ cycle: cpu_re=1, addr=0x00000010, ext_rdata=0x12345678. Expect stall high cycles 0–1, ext_req high cycle 1 only, cpu_rdata=0x12345678 and stall=0 in cycle 2, err=0.
- Write with 5-cycle ack delay: cpu_we=1, addr=0x00000100, wdata=0xCAFEF00D. Expect ext_addr/ext_wdata/ext_we stable for all 5 REQ cycles, DONE in cycle 6, cpu_rdata unchanged.
- Misaligned read addr=0x00000003: expect no ext_req, err pulse in cycle 1, cpu_rdata=0xDEADBEEF, stall low in cycle 1.
- Timeout with TIMEOUT=4 and no ack: expect ext_req high cycles 1–4, err=1 and cpu_rdata=ERR_DATA in cycle 5. A late ack in cycle 7 changes nothing.
- Boundary and conflict cases:
  - cpu_re and cpu_we both high: a write is issued.
  - Ack on the terminal-count cycle: err=0, and read data is taken from ext_rdata.
  - cpu_re held through DONE: exactly one ext_req per access.
- Reset asserted in REQ cycle 2: ext_req=0 and cpu_rdata=0 immediately (before the next clock edge). After reset release, a subsequent ext_ack causes no state change.

Source files
------------

// File: rtl/mem_bus_adapter_pkg.sv
// Shared definitions for the CPU memory-port adapter: FSM encodings,
// default error read data and the word-alignment mask.
package mem_bus_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_adapter_timeout_ctr.sv
// Purpose: cycle counter for an outstanding external request, flags the last allowed cycle.
// Latency: tc is combinational from the registered count (high while count == TIMEOUT-1).
// Backpressure: none; clear has priority over enable.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_adapter.sv
// Purpose: turns the CPU's single-cycle memory access into an ext_req/ext_ack handshake.
// Latency: request cycle 0, ext_req from cycle 1, ack in cycle k -> DONE (stall low) in cycle k+1.
// Backpressure: stall holds the CPU from the request cycle until the access completes or times out.
module mem_bus_adapter
    import mem_bus_adapter_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    output logic          err,
    output logic          ext_req,
    output logic          ext_we,
    output logic [AW-1:0] ext_addr,
    output logic [DW-1:0] ext_wdata,
    input  logic          ext_ack,
    input  logic [DW-1:0] ext_rdata
);

    state_e        state_q,     state_d;
    logic          ext_req_q,   ext_req_d;
    logic          ext_we_q,    ext_we_d;
    logic [AW-1:0] ext_addr_q,  ext_addr_d;
    logic [DW-1:0] ext_wdata_q, ext_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          err_q,       err_d;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;
    logic cpu_req;
    logic cpu_is_read;

    assign cpu_req     = cpu_re | cpu_we;
    // Store wins when both strobes are raised together.
    assign cpu_is_read = cpu_re & ~cpu_we;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .tc    (ctr_tc)
    );

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        err_d       = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    stall = 1'b1;
                    if (is_misaligned(cpu_addr[1:0])) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        if (cpu_is_read) begin
                            cpu_rdata_d = ERR_DATA;
                        end
                    end else begin
                        state_d     = ST_REQ;
                        ext_req_d   = 1'b1;
                        ext_we_d    = cpu_we;
                        ext_addr_d  = cpu_addr & ~AW'(ALIGN_MASK);
                        ext_wdata_d = cpu_wdata;
                        ctr_clr     = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                stall  = 1'b1;
                ctr_en = 1'b1;
                // An ack on the terminal-count cycle still completes cleanly.
                if (ext_ack) begin
                    state_d   = ST_DONE;
                    ext_req_d = 1'b0;
                    if (!ext_we_q) begin
                        cpu_rdata_d = ext_rdata;
                    end
                end else if (ctr_tc) begin
                    state_d   = ST_DONE;
                    ext_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!ext_we_q) begin
                        cpu_rdata_d = ERR_DATA;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                ext_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            cpu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            err_q       <= err_d;
        end
    end

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Bench for mem_bus_adapter: one instance with the default timeout, one with TIMEOUT=4,
// driven through a shared access task from a vector table, a random phase and a reset sequence.
module tb_mem_bus_adapter;

    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;
    localparam int T_A = 255;
    localparam int T_B = 4;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    logic [31:0] cpu_rdata_a, cpu_rdata_b, ext_addr_a, ext_addr_b, ext_wdata_a, ext_wdata_b;
    logic        stall_a, stall_b, err_a, err_b, ext_req_a, ext_req_b, ext_we_a, ext_we_b;

    logic [31:0] o_cpu_rdata, o_ext_addr, o_ext_wdata;
    logic        o_stall, o_err, o_ext_req, o_ext_we;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] prev_rd [2];

    typedef struct {
        bit          s;
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack;
        int          exp_done;
        int          exp_req;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    mem_bus_adapter u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we & ~sel),
        .cpu_re    (cpu_re & ~sel),
        .cpu_rdata (cpu_rdata_a),
        .stall     (stall_a),
        .err       (err_a),
        .ext_req   (ext_req_a),
        .ext_we    (ext_we_a),
        .ext_addr  (ext_addr_a),
        .ext_wdata (ext_wdata_a),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata)
    );

    mem_bus_adapter #(.TIMEOUT(T_B)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we & sel),
        .cpu_re    (cpu_re & sel),
        .cpu_rdata (cpu_rdata_b),
        .stall     (stall_b),
        .err       (err_b),
        .ext_req   (ext_req_b),
        .ext_we    (ext_we_b),
        .ext_addr  (ext_addr_b),
        .ext_wdata (ext_wdata_b),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata)
    );

    assign o_cpu_rdata = sel ? cpu_rdata_b : cpu_rdata_a;
    assign o_ext_addr  = sel ? ext_addr_b  : ext_addr_a;
    assign o_ext_wdata = sel ? ext_wdata_b : ext_wdata_a;
    assign o_stall     = sel ? stall_b     : stall_a;
    assign o_err       = sel ? err_b       : err_a;
    assign o_ext_req   = sel ? ext_req_b   : ext_req_a;
    assign o_ext_we    = sel ? ext_we_b    : ext_we_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference behaviour of one access in terms of cycle counts and results.
    function automatic void model(input bit we, input bit re, input logic [31:0] addr,
                                  input logic [31:0] rdata, input int ack, input int tmo,
                                  input logic [31:0] prev, output int done, output int req,
                                  output bit err, output logic [31:0] rd);
        bit is_read;
        is_read = re && !we;
        if (addr[1:0] != 2'b00) begin
            done = 1; req = 0; err = 1'b1;
            rd = is_read ? ERR_VAL : prev;
        end else if (ack >= 1 && ack <= tmo) begin
            done = ack + 1; req = ack; err = 1'b0;
            rd = is_read ? rdata : prev;
        end else begin
            done = tmo + 1; req = tmo; err = 1'b1;
            rd = is_read ? ERR_VAL : prev;
        end
    endfunction

    // Called just after a rising edge; the request is applied in cycle 0 and held until
    // the first cycle with stall low, then dropped one cycle later.
    task automatic run_access(input bit s, input bit we, input bit re, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                              input int exp_done, input int exp_req, input bit exp_err,
                              input logic [31:0] exp_rd, input string tag);
        int done_c = 0;
        int req_cnt = 0;
        int err_cnt = 0;
        int bad_ext = 0;
        int ncyc;
        logic [31:0] rd_at = '0;
        logic        err_at = 1'b0;
        sel       = s;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        ext_ack   = 1'b0;
        #1;
        chk({tag, "_stall_c0"}, {31'd0, o_stall}, 32'd1);
        ncyc = ((exp_done > ack) ? exp_done : ack) + 2;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (done_c != 0) begin
                cpu_we = 1'b0;
                cpu_re = 1'b0;
            end
            ext_ack   = (c == ack);
            ext_rdata = (c == ack) ? rdata : $urandom;
            #1;
            if (o_ext_req) begin
                req_cnt++;
                if (o_ext_we !== we || o_ext_addr !== {addr[31:2], 2'b00} || o_ext_wdata !== wdata)
                    bad_ext++;
            end
            if (o_err === 1'b1) err_cnt++;
            if (done_c == 0 && o_stall === 1'b0) begin
                done_c = c;
                rd_at  = o_cpu_rdata;
                err_at = o_err;
            end
        end
        ext_ack = 1'b0;
        chk({tag, "_done_cycle"}, done_c, exp_done);
        chk({tag, "_req_cycles"}, req_cnt, exp_req);
        chk({tag, "_ext_stable"}, bad_ext, 0);
        chk({tag, "_err_at_done"}, {31'd0, err_at}, {31'd0, exp_err});
        chk({tag, "_err_pulses"}, err_cnt, exp_err ? 1 : 0);
        chk({tag, "_rdata_at_done"}, rd_at, exp_rd);
        chk({tag, "_rdata_final"}, o_cpu_rdata, exp_rd);
        chk({tag, "_idle_stall"}, {31'd0, o_stall}, 32'd0);
        prev_rd[s] = exp_rd;
    endtask

    initial begin
        // Columns: inst, we, re, addr, wdata, rdata, ack, done, req_cycles, err, rdata.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h10,  32'h0,        32'h12345678, 1, 2, 1, 1'b0, 32'h12345678};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 32'h99999999, 5, 6, 5, 1'b0, 32'h12345678};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h3,   32'h0,        32'h0,        0, 1, 0, 1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h24,  32'h0,        32'hA5A5A5A5, 2, 3, 2, 1'b0, 32'hA5A5A5A5};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h20,  32'h0,        32'h11111111, 7, 5, 4, 1'b1, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h40,  32'h0BADF00D, 32'h77777777, 1, 2, 1, 1'b0, 32'hDEADBEEF};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h44,  32'h0,        32'h5EED5EED, 4, 5, 4, 1'b0, 32'h5EED5EED};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h6,   32'h1,        32'h0,        0, 1, 0, 1'b1, 32'h5EED5EED};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h80,  32'h0,        32'h0F0F0F0F, 3, 4, 3, 1'b0, 32'h0F0F0F0F};

        sel = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        ext_ack = 1'b0; ext_rdata = '0;
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_ext_req",   {31'd0, o_ext_req}, 32'd0);
        chk("rst_ext_we",    {31'd0, o_ext_we},  32'd0);
        chk("rst_ext_addr",  o_ext_addr,  32'd0);
        chk("rst_ext_wdata", o_ext_wdata, 32'd0);
        chk("rst_cpu_rdata", o_cpu_rdata, 32'd0);
        chk("rst_err",       {31'd0, o_err},   32'd0);
        chk("rst_stall",     {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_access(tbl[i].s, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                       tbl[i].ack, tbl[i].exp_done, tbl[i].exp_req, tbl[i].exp_err,
                       tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            bit          r_we, r_re, m_err;
            logic [31:0] r_addr, r_wd, r_rd, m_rd;
            int          r_ack, m_done, m_req;
            r_we   = 1'($urandom_range(0, 1));
            r_re   = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
            r_addr = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_ack  = $urandom_range(0, 6);
            model(r_we, r_re, r_addr, r_rd, r_ack, T_B, prev_rd[1], m_done, m_req, m_err, m_rd);
            run_access(1'b1, r_we, r_re, r_addr, r_wd, r_rd, r_ack, m_done, m_req, m_err, m_rd,
                       $sformatf("rnd%0d", i));
        end

        // Reset in the second REQ cycle, then a stray ack after release.
        sel = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; ext_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("rstmid_req_before", {31'd0, o_ext_req}, 32'd1);
        chk("rstmid_rd_before",  o_cpu_rdata, prev_rd[1]);
        reset = 1'b0;
        #1;
        chk("rstmid_req_after", {31'd0, o_ext_req}, 32'd0);
        chk("rstmid_rd_after",  o_cpu_rdata, 32'd0);
        cpu_re = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            ext_ack   = (c == 1);
            ext_rdata = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("post_rst_req_c%0d", c),   {31'd0, o_ext_req}, 32'd0);
            chk($sformatf("post_rst_err_c%0d", c),   {31'd0, o_err},     32'd0);
            chk($sformatf("post_rst_stall_c%0d", c), {31'd0, o_stall},   32'd0);
            chk($sformatf("post_rst_rd_c%0d", c),    o_cpu_rdata,        32'd0);
        end
        ext_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
